// File: rtl/rgbw_pkg.sv
// rgbw_pkg: shared opcodes, FSM states, channel indices and header field layout for the RGBW frame decoder
package rgbw_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_BCAST = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DISCARD
    } state_e;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int CH_W = 3;

    localparam int HDR_OP_LSB  = 6;
    localparam int HDR_OP_W    = 2;
    localparam int HDR_IDX_LSB = 0;
    localparam int HDR_IDX_W   = 2;

endpackage

// File: rtl/cs_sync.sv
// cs_sync: multi-flop synchronizer for the active-low chip-select with rise/fall pulses, idling high
module cs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift cs through the chain and keep one delayed copy of the synchronized level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], cs_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edge pulses compare the synchronized level against its previous value
    always_comb begin
        rise_o = sync_q[STAGES-1] & ~prev_q;
        fall_o = ~sync_q[STAGES-1] & prev_q;
    end

endmodule

// File: rtl/rgbw_frame_decoder.sv
// rgbw_frame_decoder: parses CS-delimited SPI frames into shadow channel registers and commits them atomically
// Optional check byte support is enabled by defining RGBW_CHECKSUM_EN.
module rgbw_frame_decoder
    import rgbw_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_CH         = 4,
    parameter int CS_SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              rdy,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] red,
    output logic [DATA_W-1:0] green,
    output logic [DATA_W-1:0] blue,
    output logic [DATA_W-1:0] white,
    output logic              update,
    output logic              frame_err,
    output logic              busy
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(NUM_CH + 2) + 1;
`ifdef RGBW_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [CW-1:0] WR_MAX = CW'(NUM_CH + EXTRA);
    localparam logic [CW-1:0] BC_MAX = CW'(1 + EXTRA);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [DATA_W-1:0] active_d [NUM_CH];
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              update_q, update_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic [DATA_W-1:0] wr_byte;
    logic              ck_ok;
    logic              rise, fall;
`ifdef RGBW_CHECKSUM_EN
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [DATA_W-1:0] xor_q, xor_d;
`endif

    cs_sync #(
        .STAGES(CS_SYNC_STAGES)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .cs_i  (cs),
        .rise_o(rise),
        .fall_o(fall)
    );

    // Frame FSM: a byte arriving with the closing edge is applied before the commit decision
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        update_d = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        ck_ok    = 1'b1;
`ifdef RGBW_CHECKSUM_EN
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        xor_d    = xor_q;
        wr_byte  = pend_q;
`else
        wr_byte  = data;
`endif
        if (state_q == IDLE) begin
            if (fall) begin
                state_d = HEADER;
                mask_d  = '0;
                cnt_d   = '0;
`ifdef RGBW_CHECKSUM_EN
                pend_v_d = 1'b0;
`endif
            end
        end else if (rdy && state_q == HEADER) begin
            op_d    = data[HDR_OP_LSB +: HDR_OP_W];
            idx_d   = IW'(data[HDR_IDX_LSB +: HDR_IDX_W]);
            state_d = (op_d == OP_ILL) ? DISCARD : PAYLOAD;
`ifdef RGBW_CHECKSUM_EN
            xor_d   = data;
`endif
        end else if (rdy && state_q == PAYLOAD && op_q != OP_NOP) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d > ((op_q == OP_BCAST) ? BC_MAX : WR_MAX)) begin
                state_d = DISCARD;
            end else begin
`ifdef RGBW_CHECKSUM_EN
                // The newest byte may be the check byte, so only the previous one is written
                wr_en    = pend_v_q;
                pend_d   = data;
                pend_v_d = 1'b1;
                xor_d    = pend_v_q ? (xor_q ^ pend_q) : xor_q;
`else
                wr_en    = 1'b1;
`endif
            end
        end
        if (wr_en) begin
            if (op_q == OP_BCAST) begin
                for (int c = 0; c < NUM_CH; c++) shadow_d[c] = wr_byte;
                mask_d = '1;
            end else begin
                shadow_d[idx_q] = wr_byte;
                mask_d[idx_q]   = 1'b1;
                idx_d           = idx_q + IW'(1);
            end
        end
        if (state_q != IDLE && rise) begin
`ifdef RGBW_CHECKSUM_EN
            ck_ok = (pend_d == xor_d);
`endif
            update_d = state_d == PAYLOAD && (op_q == OP_WRITE || op_q == OP_BCAST) && |mask_d && ck_ok;
            err_d    = state_d == DISCARD || (state_d == PAYLOAD && op_q != OP_NOP && cnt_d != '0 && !ck_ok);
            state_d  = IDLE;
        end
        for (int c = 0; c < NUM_CH; c++) active_d[c] = (update_d && mask_d[c]) ? shadow_d[c] : active_q[c];
    end

    // State, shadow and active registers; reset abandons any open frame silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OP_NOP;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
`ifdef RGBW_CHECKSUM_EN
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            update_q <= update_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
`ifdef RGBW_CHECKSUM_EN
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            xor_q    <= xor_d;
`endif
        end
    end

    assign red       = active_q[CH_R];
    assign green     = active_q[CH_G];
    assign blue      = active_q[CH_B];
    assign white     = active_q[CH_W];
    assign update    = update_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// tb_rgbw_frame_decoder: directed frames with a scoreboard of expected commit/error outcomes and channel values
module tb_rgbw_frame_decoder;

    localparam int SYNC   = 2;
    localparam int K_NONE = 0;
    localparam int K_UPD  = 1;
    localparam int K_ERR  = 2;
    localparam int WIN    = 10;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;
        logic [31:0] ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] red, green, blue, white;
    logic       update, frame_err, busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    rgbw_frame_decoder #(
        .DATA_W        (8),
        .NUM_CH        (4),
        .CS_SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .rdy      (rdy),
        .data     (data),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .white    (white),
        .update   (update),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] ch);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rdy  = 1'b1;
        data = b;
        @(negedge clk);
        rdy  = 1'b0;
    endtask

    // Watch the pulses after cs rises; optionally inject one byte on the closing edge
    task automatic observe(input bit late, input logic [7:0] lb);
        exp_t e;
        int   upd_n = 0;
        int   err_n = 0;
        int   first_upd = 0;
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            if (late && i == 2) begin
                rdy  = 1'b1;
                data = lb;
            end
            if (late && i == 3) rdy = 1'b0;
            if (update) begin
                upd_n++;
                if (first_upd == 0) first_upd = i;
            end
            if (frame_err) err_n++;
        end
        e = sb.pop_front();
        check("update_count", 32'(upd_n), 32'(e.kind == K_UPD));
        check("frame_err_count", 32'(err_n), 32'(e.kind == K_ERR));
        if (e.kind == K_UPD && !late) check("commit_latency", 32'(first_upd), 32'(SYNC + 1));
        check("rgbw", {red, green, blue, white}, e.ch);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic frame(input bq_t b, input bit late);
        int n;
        n = late ? b.size() - 1 : b.size();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_open", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) send_byte(b[i]);
        @(negedge clk);
        cs = 1'b1;
        observe(late, late ? b[b.size()-1] : 8'h00);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rgbw", {red, green, blue, white}, 32'h0);
        check("reset_update", 32'(update), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
`ifdef RGBW_CHECKSUM_EN
        push_exp(K_UPD, 32'h01020304);
        frame('{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h44}, 1'b0);
        push_exp(K_ERR, 32'h01020304);
        frame('{8'h40, 8'h11, 8'h12, 8'h13, 8'h14, 8'h45}, 1'b0);
        push_exp(K_UPD, 32'h09090909);
        frame('{8'h80, 8'h09, 8'h89}, 1'b0);
`else
        push_exp(K_UPD, 32'h10203040);
        frame('{8'h40, 8'h10, 8'h20, 8'h30, 8'h40}, 1'b0);
        push_exp(K_UPD, 32'hBB2030AA);
        frame('{8'h43, 8'hAA, 8'hBB}, 1'b0);
        push_exp(K_UPD, 32'h7F7F7F7F);
        frame('{8'h80, 8'h7F}, 1'b0);
        push_exp(K_ERR, 32'h7F7F7F7F);
        frame('{8'h80, 8'h01, 8'h02}, 1'b0);
        push_exp(K_ERR, 32'h7F7F7F7F);
        frame('{8'hC0, 8'h11}, 1'b0);
        push_exp(K_ERR, 32'h7F7F7F7F);
        frame('{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0);
        push_exp(K_NONE, 32'h7F7F7F7F);
        frame('{8'h00, 8'h55}, 1'b0);
        push_exp(K_NONE, 32'h7F7F7F7F);
        frame('{8'h40}, 1'b0);
        push_exp(K_UPD, 32'h7F667F7F);
        frame('{8'h41, 8'h66}, 1'b1);
        push_exp(K_NONE, 32'h0);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h40);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        reset = 1'b1;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_rgbw", {red, green, blue, white}, 32'h0);
        check("midreset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        observe(1'b0, 8'h00);
        push_exp(K_UPD, 32'h01020304);
        frame('{8'h40, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
`endif
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
